note_feeder: RTL and testbench

- Drives the input end of one DDR light column (cells L0..L4).
- Injects notes into the bottom cell via its BL input, paced by an LFSR with a minimum spacing between notes.
- Derives the TOP_POS bus that all cells in the column share, from their lighton outputs.
- Sequences a song of fixed note count: idle, run, drain until the column is empty, done.

---
 rtl/note_feeder_pkg.sv | 25 ++
 rtl/top_pos_enc.sv | 18 +
 rtl/note_feeder.sv | 98 +++++++++
 tb/tb_note_feeder.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/note_feeder_pkg.sv
// Shared types and constants for the note feeder and the light-column cells.
package note_feeder_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'b00,
      StRun   = 2'b01,
      StDrain = 2'b10,
      StDone  = 2'b11
   } state_e;

   localparam logic [2:0] TopPosNone = 3'b000;
   localparam logic [2:0] TopPos0    = 3'b001;
   localparam logic [2:0] TopPos1    = 3'b010;
   localparam logic [2:0] TopPos2    = 3'b011;
   localparam logic [2:0] TopPos3    = 3'b100;
   localparam logic [2:0] TopPos4    = 3'b101;

   // x^8 + x^6 + x^5 + x^4 + 1 -> feedback from bits 7, 5, 4, 3
   localparam logic [7:0] LfsrTaps = 8'hB8;

   function automatic logic [7:0] lfsr_step(input logic [7:0] v);
      return {v[6:0], ^(v & LfsrTaps)};
   endfunction

endpackage

// File: rtl/top_pos_enc.sv
// 5->3 priority encoder: highest lit cell of a column wins.
module top_pos_enc
   import note_feeder_pkg::*;
(
   input  logic [4:0] lights_i,
   output logic [2:0] top_pos_o
);

   always_comb begin
      top_pos_o = TopPosNone;
      if (lights_i[4])      top_pos_o = TopPos4;
      else if (lights_i[3]) top_pos_o = TopPos3;
      else if (lights_i[2]) top_pos_o = TopPos2;
      else if (lights_i[1]) top_pos_o = TopPos1;
      else if (lights_i[0]) top_pos_o = TopPos0;
   end

endmodule

// File: rtl/note_feeder.sv
// Feeds notes into the bottom cell of one light column and sequences a song
// of fixed length: idle, run, drain until the column is empty, done.
module note_feeder
   import note_feeder_pkg::*;
#(
   parameter logic [7:0]  SEED     = 8'hA5,
   parameter int unsigned DENSITY  = 4,
   parameter int unsigned GAP_MIN  = 2,
   parameter int unsigned SONG_LEN = 16
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       start,
   input  logic       pause,
   input  logic [4:0] lights,
   output logic       BL0,
   output logic [2:0] TOP_POS,
   output logic [7:0] notes_left,
   output logic       busy,
   output logic       done
);

   // An all-zero seed would lock the LFSR up
   localparam logic [7:0] SeedEff = (SEED == 8'h00) ? 8'h01 : SEED;
   localparam logic [3:0] GapMin  = 4'(GAP_MIN);
   localparam logic [3:0] Density = 4'(DENSITY);
   localparam logic [7:0] SongLen = 8'(SONG_LEN);

   state_e     state_q, state_d;
   logic [7:0] lfsr_q, lfsr_d;
   logic [3:0] gap_q, gap_d;
   logic [7:0] notes_q, notes_d;
   logic       bl0_q, bl0_d;
   logic       spawn;

   always_comb begin
      state_d = state_q;
      lfsr_d  = lfsr_q;
      gap_d   = gap_q;
      notes_d = notes_q;
      bl0_d   = 1'b0;
      spawn   = (gap_q >= GapMin) && ({1'b0, lfsr_q[2:0]} < Density) && (notes_q != 8'd0);

      unique case (state_q)
         StIdle, StDone: begin
            if (start) begin
               state_d = StRun;
               notes_d = SongLen;
               gap_d   = GapMin;
            end
         end
         StRun: begin
            if (!pause) begin
               lfsr_d = lfsr_step(lfsr_q);
               bl0_d  = spawn;
               if (spawn) begin
                  gap_d   = 4'd0;
                  notes_d = notes_q - 8'd1;
                  if (notes_q == 8'd1) state_d = StDrain;
               end else if (gap_q != 4'hF) begin
                  gap_d = gap_q + 4'd1;
               end
            end
         end
         StDrain: begin
            if (lights == 5'b00000) state_d = StDone;
         end
         default: ;
      endcase
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q <= StIdle;
         lfsr_q  <= SeedEff;
         gap_q   <= GapMin;
         notes_q <= SongLen;
         bl0_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         lfsr_q  <= lfsr_d;
         gap_q   <= gap_d;
         notes_q <= notes_d;
         bl0_q   <= bl0_d;
      end
   end

   top_pos_enc u_top_pos_enc (
      .lights_i  (lights),
      .top_pos_o (TOP_POS)
   );

   assign BL0        = bl0_q;
   assign notes_left = notes_q;
   assign busy       = (state_q == StRun) || (state_q == StDrain);
   assign done       = (state_q == StDone);

endmodule

// File: tb/tb_note_feeder.sv
// Scoreboard bench: expected BL0 pulse cycles are queued at stimulus time and
// a negedge monitor pops one per observed pulse.
module tb_note_feeder;
   import note_feeder_pkg::*;

   logic       Clock = 1'b0;
   logic       Reset = 1'b1;
   logic       start_a = 1'b0, pause_a = 1'b0;
   logic [4:0] lights_a = 5'b0;
   logic       bl0_a, busy_a, done_a;
   logic [2:0] top_pos_a;
   logic [7:0] notes_a;
   logic       start_b = 1'b0, pause_b = 1'b0;
   logic [4:0] lights_b = 5'b0;
   logic       bl0_b, busy_b, done_b;
   logic [2:0] top_pos_b;
   logic [7:0] notes_b;

   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   qa[$];
   int   qb[$];
   logic prev_a = 1'b0;
   int   s, s2, s3;

   logic [4:0] lv[5] = '{5'b00000, 5'b00001, 5'b00110, 5'b10001, 5'b01000};
   logic [2:0] tv[5] = '{3'b000, 3'b001, 3'b011, 3'b101, 3'b100};

   note_feeder #(.SEED(8'hA5), .DENSITY(8), .GAP_MIN(2), .SONG_LEN(4)) dut_a (
      .Clock      (Clock),
      .Reset      (Reset),
      .start      (start_a),
      .pause      (pause_a),
      .lights     (lights_a),
      .BL0        (bl0_a),
      .TOP_POS    (top_pos_a),
      .notes_left (notes_a),
      .busy       (busy_a),
      .done       (done_a)
   );

   // Zero seed must fall back to 8'h01
   note_feeder #(.SEED(8'h00), .DENSITY(4), .GAP_MIN(1), .SONG_LEN(3)) dut_b (
      .Clock      (Clock),
      .Reset      (Reset),
      .start      (start_b),
      .pause      (pause_b),
      .lights     (lights_b),
      .BL0        (bl0_b),
      .TOP_POS    (top_pos_b),
      .notes_left (notes_b),
      .busy       (busy_b),
      .done       (done_b)
   );

   always #5 Clock = ~Clock;
   always @(posedge Clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [7:0] lfsr_adv(input logic [7:0] v, input int n);
      logic [7:0] r;
      r = v;
      for (int i = 0; i < n; i++) r = {r[6:0], r[7] ^ r[5] ^ r[4] ^ r[3]};
      return r;
   endfunction

   always @(negedge Clock) begin
      if (bl0_a) begin
         check("bl0_a_back_to_back", 32'(prev_a), 32'd0);
         if (qa.size() == 0) check("bl0_a_spurious", 32'(cyc), 32'hFFFF_FFFF);
         else check("bl0_a_cycle", 32'(cyc), 32'(qa.pop_front()));
      end
      if (bl0_b) begin
         if (qb.size() == 0) check("bl0_b_spurious", 32'(cyc), 32'hFFFF_FFFF);
         else check("bl0_b_cycle", 32'(cyc), 32'(qb.pop_front()));
      end
      prev_a <= bl0_a;
   end

   initial begin
      repeat (2) @(negedge Clock);
      Reset = 1'b0;
      repeat (5) @(negedge Clock);
      check("rst_bl0", 32'(bl0_a), 32'd0);
      check("rst_top_pos", 32'(top_pos_a), 32'd0);
      check("rst_notes", 32'(notes_a), 32'd4);
      check("rst_busy", 32'(busy_a), 32'd0);
      check("rst_done", 32'(done_a), 32'd0);
      check("rst_lfsr", 32'(dut_a.lfsr_q), 32'hA5);
      check("rst_lfsr_zero_seed", 32'(dut_b.lfsr_q), 32'h01);

      for (int i = 0; i < 5; i++) begin
         lights_a = lv[i];
         #1;
         check("top_pos", 32'(top_pos_a), 32'(tv[i]));
      end
      lights_a = 5'b0;

      // Song 1: A pulses every GAP_MIN+1 clocks; B paced by LFSR 01,02,04,08,11,23
      @(negedge Clock);
      start_a = 1'b1;
      start_b = 1'b1;
      s = cyc + 1;
      qa.push_back(s + 1); qa.push_back(s + 4); qa.push_back(s + 7); qa.push_back(s + 10);
      qb.push_back(s + 1); qb.push_back(s + 4); qb.push_back(s + 6);
      @(negedge Clock);
      start_a = 1'b0;
      start_b = 1'b0;
      check("run_busy", 32'(busy_a), 32'd1);
      check("run_notes", 32'(notes_a), 32'd4);
      for (int k = 1; k <= 10; k++) begin
         @(negedge Clock);
         if (k % 3 == 1) check("run_notes_step", 32'(notes_a), 32'(3 - (k - 1) / 3));
      end
      check("song1_drain", 32'(dut_a.state_q), 32'(StDrain));
      check("song1_lfsr", 32'(dut_a.lfsr_q), 32'(lfsr_adv(8'hA5, 10)));
      check("b_done", 32'(done_b), 32'd1);
      check("b_notes", 32'(notes_b), 32'd0);
      check("b_lfsr", 32'(dut_b.lfsr_q), 32'h47);

      // Drain with a lit cell while start is held: must stay busy
      lights_a = 5'b00100;
      start_a  = 1'b1;
      repeat (3) begin
         @(negedge Clock);
         check("drain_busy", 32'(busy_a), 32'd1);
         check("drain_done", 32'(done_a), 32'd0);
      end
      lights_a = 5'b00000;
      @(negedge Clock);
      check("drain_to_done", 32'(done_a), 32'd1);
      check("drain_to_done_busy", 32'(busy_a), 32'd0);

      // start still high: restart from DONE
      s2 = cyc + 1;
      qa.push_back(s2 + 1); qa.push_back(s2 + 4); qa.push_back(s2 + 13); qa.push_back(s2 + 16);
      @(negedge Clock);
      start_a = 1'b0;
      check("restart_notes", 32'(notes_a), 32'd4);
      check("restart_busy", 32'(busy_a), 32'd1);
      check("restart_done", 32'(done_a), 32'd0);

      repeat (5) @(negedge Clock);
      pause_a = 1'b1;
      check("pre_pause_notes", 32'(notes_a), 32'd2);
      check("pre_pause_lfsr", 32'(dut_a.lfsr_q), 32'(lfsr_adv(8'hA5, 15)));
      repeat (6) @(negedge Clock);
      check("pause_bl0", 32'(bl0_a), 32'd0);
      check("pause_notes", 32'(notes_a), 32'd2);
      check("pause_lfsr", 32'(dut_a.lfsr_q), 32'(lfsr_adv(8'hA5, 15)));
      pause_a = 1'b0;
      repeat (5) @(negedge Clock);
      check("song2_notes", 32'(notes_a), 32'd0);
      check("song2_drain", 32'(dut_a.state_q), 32'(StDrain));
      check("song2_lfsr", 32'(dut_a.lfsr_q), 32'(lfsr_adv(8'hA5, 20)));
      @(negedge Clock);
      check("song2_done", 32'(done_a), 32'd1);

      // Song 3: reset mid-clock while BL0 is high
      start_a = 1'b1;
      s3 = cyc + 1;
      qa.push_back(s3 + 1);
      @(negedge Clock);
      start_a = 1'b0;
      @(negedge Clock);
      check("pre_reset_bl0", 32'(bl0_a), 32'd1);
      #2;
      Reset = 1'b1;
      #1;
      check("async_rst_bl0", 32'(bl0_a), 32'd0);
      check("async_rst_state", 32'(dut_a.state_q), 32'(StIdle));
      check("async_rst_notes", 32'(notes_a), 32'd4);
      check("async_rst_lfsr", 32'(dut_a.lfsr_q), 32'hA5);
      check("async_rst_busy", 32'(busy_a), 32'd0);
      @(negedge Clock);
      Reset = 1'b0;
      repeat (2) @(negedge Clock);

      check("qa_drained", 32'(qa.size()), 32'd0);
      check("qb_drained", 32'(qb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
